spi_frame_seq: RTL and testbench

- Upstream sequencer for the `spi` master core. It turns a byte stream from the host into chip-select-framed SPI transactions.
- Buffers host TX bytes in a FIFO and issues them one at a time on the core's transfer/ready handshake.
- Drives cs_n with programmable setup, hold and idle gaps.
- Collects each received byte, with its end-of-frame flag, into an RX FIFO for the host.

---
 rtl/spi_frame_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_spi_frame_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_seq.sv
// spi_frame_seq -- upstream frame sequencer for the `spi` master core.
//
// Takes host words, each tagged with an end-of-frame flag. They wait in a TX
// FIFO. The sequencer sends them to the core one at a time over the
// transfer/ready handshake, and the word sent is the TX FIFO head at the
// moment of issue. Chip select is framed with programmable setup, hold and
// idle gaps. Each received word and its end-of-frame flag go into an RX FIFO
// (show-ahead) that the host reads.
//
// Ports:
//   clk                in   system clock, rising edge
//   rst                in   asynchronous reset, active low
//   tx_data/tx_last    in   host word and its end-of-frame flag
//   tx_valid           in   host write request
//   tx_ready           out  TX FIFO not full
//   rx_data/rx_last    out  RX FIFO head word and its end-of-frame flag
//   rx_valid           out  RX FIFO not empty
//   rx_ready           in   host read acknowledge
//   spi_transmit_data  out  word presented to the core
//   spi_transfer       out  one-cycle start pulse to the core
//   spi_ready          in   core idle / word finished
//   spi_received_data  in   word received by the core
//   cs_n               out  active-low chip select
//   busy               out  sequencer not idle
module spi_frame_seq #(
    parameter int DL       = 8,
    parameter int DEPTH    = 16,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_IDLE  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DL-1:0] tx_data,
    input  logic          tx_last,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [DL-1:0] rx_data,
    output logic          rx_last,
    output logic          rx_valid,
    input  logic          rx_ready,
    output logic [DL-1:0] spi_transmit_data,
    output logic          spi_transfer,
    input  logic          spi_ready,
    input  logic [DL-1:0] spi_received_data,
    output logic          cs_n,
    output logic          busy
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int GMAX_A = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int GMAX   = (GMAX_A > CS_IDLE) ? GMAX_A : CS_IDLE;
    localparam int GW     = $clog2(GMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_HOLD,
        S_GAP
    } state_t;

    // ---------------- TX FIFO ----------------
    logic [DL:0]   r_tx_mem [DEPTH];
    logic [AW-1:0] r_tx_wp;
    logic [AW-1:0] r_tx_rp;
    logic [CW-1:0] r_tx_cnt;
    logic          w_tx_push;
    logic          w_tx_pop;
    logic          w_tx_empty;
    logic [DL:0]   w_tx_head;

    assign tx_ready   = (r_tx_cnt != CW'(DEPTH));
    assign w_tx_push  = tx_valid & tx_ready;
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_head  = r_tx_mem[r_tx_rp];

    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wp] <= {tx_last, tx_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + CW'(1);
                2'b01:   r_tx_cnt <= r_tx_cnt - CW'(1);
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // ---------------- RX FIFO (show-ahead) ----------------
    logic [DL:0]   r_rx_mem [DEPTH];
    logic [AW-1:0] r_rx_wp;
    logic [AW-1:0] r_rx_rp;
    logic [CW-1:0] r_rx_cnt;
    logic          w_rx_push;
    logic          w_rx_pop;
    logic          w_rx_full;
    logic [DL:0]   w_rx_head;
    logic          r_last;

    assign rx_valid  = (r_rx_cnt != '0);
    assign w_rx_full = (r_rx_cnt == CW'(DEPTH));
    assign w_rx_pop  = rx_valid & rx_ready;
    assign w_rx_head = r_rx_mem[r_rx_rp];
    // The memory is not reset, so the head is masked to zero while the FIFO is empty.
    assign rx_data   = rx_valid ? w_rx_head[DL-1:0] : '0;
    assign rx_last   = rx_valid & w_rx_head[DL];

    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wp] <= {r_last, spi_received_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1);
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + CW'(1);
                2'b01:   r_rx_cnt <= r_rx_cnt - CW'(1);
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    // ---------------- Frame FSM ----------------
    state_t        r_state;
    state_t        w_state_nxt;
    logic [GW-1:0] r_cnt;
    logic [GW-1:0] w_cnt_nxt;
    logic          r_cs_n;
    logic          r_transfer;
    logic [DL-1:0] r_tx_word;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tx_pop    = 1'b0;
        w_rx_push   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_tx_empty) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = GW'(CS_SETUP);
                end
            end
            S_SETUP: begin
                if (r_cnt <= GW'(1)) w_state_nxt = S_ISSUE;
                else                 w_cnt_nxt   = r_cnt - GW'(1);
            end
            S_ISSUE: begin
                // RX room is reserved here, so the push in WAIT_DONE can never overflow.
                if (!w_tx_empty && !w_rx_full && spi_ready) begin
                    w_tx_pop    = 1'b1;
                    w_state_nxt = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (!spi_ready) w_state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (spi_ready) begin
                    w_rx_push = 1'b1;
                    if (r_last) begin
                        w_state_nxt = S_HOLD;
                        w_cnt_nxt   = GW'(CS_HOLD);
                    end else begin
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_HOLD: begin
                if (r_cnt <= GW'(1)) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = GW'(CS_IDLE);
                end else begin
                    w_cnt_nxt = r_cnt - GW'(1);
                end
            end
            S_GAP: begin
                if (r_cnt <= GW'(1)) w_state_nxt = S_IDLE;
                else                 w_cnt_nxt   = r_cnt - GW'(1);
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_cs_n     <= 1'b1;
            r_transfer <= 1'b0;
            r_tx_word  <= '0;
            r_last     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            // Chip select is registered from the next state, so it changes cleanly on the transition.
            r_cs_n     <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_GAP);
            r_transfer <= w_tx_pop;
            if (w_tx_pop) begin
                r_tx_word <= w_tx_head[DL-1:0];
                r_last    <= w_tx_head[DL];
            end
        end
    end

    assign spi_transmit_data = r_tx_word;
    assign spi_transfer      = r_transfer;
    assign cs_n              = r_cs_n;
    assign busy              = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_frame_seq.sv
// Testbench for spi_frame_seq with a behavioural SPI core model (MISO looped to MOSI).
module tb_spi_frame_seq;
  localparam int DL = 8, DEPTH = 16, CS_SETUP = 4, CS_HOLD = 4, CS_IDLE = 4, LAT = 20;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] tx_data = '0;
  logic tx_last = 1'b0, tx_valid = 1'b0;
  logic tx_ready;
  logic [7:0] rx_data;
  logic rx_last, rx_valid;
  logic rx_ready = 1'b0;
  logic [7:0] spi_transmit_data;
  logic spi_transfer;
  logic spi_ready = 1'b1;
  logic [7:0] spi_received_data = '0;
  logic cs_n, busy;

  always #5 clk = ~clk;

  spi_frame_seq #(.DL(DL), .DEPTH(DEPTH), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)) dut (
    .clk(clk), .rst(rst),
    .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_last(rx_last), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .spi_transmit_data(spi_transmit_data), .spi_transfer(spi_transfer),
    .spi_ready(spi_ready), .spi_received_data(spi_received_data),
    .cs_n(cs_n), .busy(busy)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic [7:0] ed;
    logic       el;
  } vec_t;

  int checks = 0, failures = 0;
  int cyc = 0, n_xfer = 0, n_fall = 0;
  int fall_cyc = 0, rise_cyc = 0, done_cyc = 0, core_cnt = 0;
  bit have_rise = 0, first_after_fall = 0, rx_en = 0;
  logic prev_cs = 1'b1, prev_xfer = 1'b0;
  logic [7:0] core_sh = '0;
  logic [8:0] exp_q[$];
  logic [8:0] exp_w;
  vec_t vt[6];
  int base_x, base_f, t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_true(input string name, input bit c);
    checks++;
    if (!c) begin
      failures++;
      $display("FAIL %s: got 0 expected 1", name);
    end
  endtask

  // Monitor, SPI core model and RX consumer share one negedge process so their order is fixed.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (spi_transfer) begin
        n_xfer++;
        chk("xfer_pulse_width", {31'd0, prev_xfer}, 32'd0);
        if (first_after_fall) begin
          chk_true("cs_setup_time", (cyc - fall_cyc) >= CS_SETUP);
          first_after_fall = 0;
        end
      end
      if (prev_cs && !cs_n) begin
        n_fall++;
        fall_cyc = cyc;
        first_after_fall = 1;
        if (have_rise) chk_true("cs_idle_gap", (cyc - rise_cyc) >= CS_IDLE);
      end
      if (!prev_cs && cs_n) begin
        rise_cyc = cyc;
        have_rise = 1;
        chk_true("cs_hold_time", (cyc - done_cyc) >= CS_HOLD && (cyc - done_cyc) <= CS_HOLD + 3);
      end
      if (!spi_ready) chk("cs_low_during_xfer", {31'd0, cs_n}, 32'd0);
    end else begin
      have_rise = 0;
      first_after_fall = 0;
    end
    prev_cs = cs_n;
    prev_xfer = spi_transfer;

    // SPI core: takes LAT cycles per word and echoes the transmitted word back.
    if (!rst) begin
      spi_ready = 1'b1;
      core_cnt = 0;
    end else if (spi_ready && spi_transfer) begin
      core_sh = spi_transmit_data;
      spi_ready = 1'b0;
      core_cnt = LAT;
    end else if (!spi_ready) begin
      core_cnt--;
      if (core_cnt == 0) begin
        spi_ready = 1'b1;
        spi_received_data = core_sh;
        done_cyc = cyc;
      end
    end

    // Host RX side: compare head against the scoreboard, pop on the next edge.
    if (rst && rx_en && rx_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected: got %0h expected none", {rx_last, rx_data});
      end else begin
        exp_w = exp_q.pop_front();
        chk("rx_word", {23'd0, rx_last, rx_data}, {23'd0, exp_w});
      end
      rx_ready = 1'b1;
    end else begin
      rx_ready = 1'b0;
    end
  end

  task automatic host_write(input logic [7:0] d, input logic l);
    int tw;
    tw = 0;
    @(negedge clk);
    tx_data = d;
    tx_last = l;
    tx_valid = 1'b1;
    while (!tx_ready && tw < 2000) begin
      @(negedge clk);
      tw++;
    end
    if (!tx_ready) begin
      checks++;
      failures++;
      $display("FAIL tx_write_timeout: tx_ready=0 expected 1");
    end
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int tw;
    tw = 0;
    while ((busy || exp_q.size() != 0) && tw < 5000) begin
      @(negedge clk);
      tw++;
    end
    chk_true(name, !busy && exp_q.size() == 0);
  endtask

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst_transfer", {31'd0, spi_transfer}, 32'd0);
    chk("rst_tx_data_out", {24'd0, spi_transmit_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_rx_last", {31'd0, rx_last}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    rx_en = 1;

    // Single word, three-word frame, two back-to-back single-word frames.
    vt[0] = '{8'hAA, 1'b1, 8'hAA, 1'b1};
    vt[1] = '{8'h11, 1'b0, 8'h11, 1'b0};
    vt[2] = '{8'h22, 1'b0, 8'h22, 1'b0};
    vt[3] = '{8'h33, 1'b1, 8'h33, 1'b1};
    vt[4] = '{8'hA5, 1'b1, 8'hA5, 1'b1};
    vt[5] = '{8'h5A, 1'b1, 8'h5A, 1'b1};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({vt[i].el, vt[i].ed});
      host_write(vt[i].d, vt[i].l);
      if (vt[i].l) wait_idle("frame_done");
    end
    chk("table_xfer_count", n_xfer, 6);
    chk("table_cs_falls", n_fall, 4);

    // TX starvation mid-frame: cs_n stays low until the next word arrives.
    base_x = n_xfer;
    base_f = n_fall;
    exp_q.push_back({1'b0, 8'h01});
    host_write(8'h01, 1'b0);
    repeat (300) @(negedge clk);
    chk("starve_cs_low", {31'd0, cs_n}, 32'd0);
    chk("starve_busy", {31'd0, busy}, 32'd1);
    chk("starve_xfer_count", n_xfer - base_x, 1);
    exp_q.push_back({1'b1, 8'h02});
    host_write(8'h02, 1'b1);
    wait_idle("starve_done");
    chk("starve_xfer_total", n_xfer - base_x, 2);
    chk("starve_one_frame", n_fall - base_f, 1);

    // RX backpressure: RX fills, transfers stop, TX fills, then drain in order.
    rx_en = 0;
    base_x = n_xfer;
    base_f = n_fall;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      exp_q.push_back({(i == 2 * DEPTH - 1), 8'(8'h40 + i)});
      host_write(8'(8'h40 + i), (i == 2 * DEPTH - 1));
    end
    repeat (700) @(negedge clk);
    chk("bp_xfer_stalled", n_xfer - base_x, DEPTH);
    chk("bp_tx_full", {31'd0, tx_ready}, 32'd0);
    chk("bp_rx_valid", {31'd0, rx_valid}, 32'd1);
    chk("bp_cs_low", {31'd0, cs_n}, 32'd0);
    rx_en = 1;
    wait_idle("bp_done");
    chk("bp_xfer_total", n_xfer - base_x, 2 * DEPTH);
    chk("bp_one_frame", n_fall - base_f, 1);

    // Asynchronous reset during the second word of a frame.
    base_x = n_xfer;
    exp_q.push_back({1'b0, 8'h10});
    exp_q.push_back({1'b0, 8'h20});
    exp_q.push_back({1'b1, 8'h30});
    host_write(8'h10, 1'b0);
    host_write(8'h20, 1'b0);
    host_write(8'h30, 1'b1);
    t = 0;
    while ((n_xfer - base_x) < 2 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("rst_reach_word2", n_xfer - base_x, 2);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("midrst_transfer", {31'd0, spi_transfer}, 32'd0);
    chk("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    base_x = n_xfer;
    exp_q.push_back({1'b1, 8'hC3});
    host_write(8'hC3, 1'b1);
    wait_idle("rst_recover_done");
    chk("rst_recover_xfers", n_xfer - base_x, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
